mmio_uart_tx: RTL

Memory-mapped UART transmitter on the CPU data bus, alongside `dmem`. Snoops the CPU store interface (`MemWrite`, `DataAdr`, `WriteData`) and claims a small address window. Bytes stored to the data register enter a FIFO and are serialised 8N1, LSB first, on `tx`. A status register is readable through a dedicated read-data port, muxed with `dmem` read data at top level.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 24 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_ACTIVE = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus slice seen by the UART: store strobe, address, store data and
// the register read-data return path.
interface mmio_uart_tx_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output ReadData
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop frees an entry on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops CPU stores into TXDATA/STATUS,
// queues bytes in a FIFO and shifts them out LSB first on tx.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int              BW         = $clog2(CLKS_PER_BIT);
  localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     TXDATA_ADR = ADDR_BASE + TXDATA_OFS;
  localparam logic [31:0]     STATUS_ADR = ADDR_BASE + STATUS_OFS;

  tx_state_t       state;
  tx_state_t       state_next;
  logic [BW-1:0]   baud_cnt;
  logic [BW-1:0]   baud_next;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_next;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_next;
  logic            baud_done;
  logic            overflow;
  logic            active;

  logic            sel_txdata;
  logic            sel_status;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      fifo_head;
  logic [1:0]      cnt_field;
  logic [31:0]     status_word;
  logic            unused_wdata;

  assign sel_txdata = (bus.DataAdr == TXDATA_ADR);
  assign sel_status = (bus.DataAdr == STATUS_ADR);
  assign push       = bus.MemWrite && sel_txdata;

  // Only the low byte of a TXDATA store is transmitted.
  assign unused_wdata = ^bus.WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.WriteData[7:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A store to a full FIFO is lost unless the FSM frees a slot on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (bus.MemWrite && sel_status) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  // The stop bit hands straight to the next start bit when data is waiting,
  // so queued bytes go out with no idle gap.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) begin
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shift_reg[0];
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        tx = 1'b1;
        if (baud_done) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign active = (state != IDLE);
  assign busy   = active || !fifo_empty;

  // Two count bits only; deeper occupancy reads as 3 and full tells the rest.
  assign cnt_field = (int'(fifo_count) > 3) ? 2'b11 : fifo_count[1:0];

  always_comb begin
    status_word                      = '0;
    status_word[STAT_FULL]           = fifo_full;
    status_word[STAT_EMPTY]          = fifo_empty;
    status_word[STAT_ACTIVE]         = active;
    status_word[STAT_OVF]            = overflow;
    status_word[STAT_CNT_LO +: 2]    = cnt_field;
  end

  assign bus.ReadData = sel_status ? status_word : 32'h0;

endmodule
